legv8_control_unit: RTL

//  Multi-cycle FSM control unit that produces the 40-bit ControlWord consumed by LEGv8_Datapath_TS.

---
 rtl/legv8_pkg.sv | 160 ++++++++++++++++
 rtl/legv8_control_unit_if.sv | 34 +++
 rtl/legv8_imm_extend.sv | 30 +++
 rtl/legv8_control_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// ---------------------------------------------------------------------------
// legv8_pkg
// Shared definitions for the LEGv8 multi-cycle control unit: FSM state
// encodings, ALU function-select codes, mem_op / pc_fs field codes, opcode
// constants, ControlWord bit positions and a few helper functions.
//
// Optional feature macro: LEGV8_CU_BCOND_EN (adds the B.cond opcode constant).
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package legv8_pkg;

    localparam int CW_W   = 40;
    localparam int DATA_W = 64;

    localparam logic [4:0] XZR = 5'd31;

    // FSM states; the numeric values are visible on the debug state output.
    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [4:0] {
        FS_AND = 5'b00000,
        FS_ORR = 5'b00100,
        FS_ADD = 5'b01000,
        FS_SUB = 5'b01001
    } fs_t;

    typedef enum logic [1:0] {
        MEM_NONE   = 2'b00,
        MEM_WRITE  = 2'b01,
        MEM_IFETCH = 2'b10,
        MEM_DREAD  = 2'b11
    } mem_op_t;

    typedef enum logic [1:0] {
        PC_HOLD = 2'b00,
        PC_INC  = 2'b01,
        PC_LOAD = 2'b10,
        PC_REL  = 2'b11
    } pc_fs_t;

    // Immediate formats understood by legv8_imm_extend.
    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_D    = 3'd2,
        IMM_B    = 3'd3,
        IMM_CB   = 3'd4
    } imm_fmt_t;

    // Opcode constants, grouped by the width of the opcode field.
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_HLT  = 11'b11111111111;
    localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
    localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
    localparam logic [9:0]  OPC_ANDI = 10'b1001001000;
    localparam logic [9:0]  OPC_ORRI = 10'b1011001000;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [7:0]  OPC_CBNZ = 8'b10110101;
    localparam logic [5:0]  OPC_B    = 6'b000101;
`ifdef LEGV8_CU_BCOND_EN
    localparam logic [7:0]  OPC_BCOND = 8'h54;
`endif

    // ControlWord field positions (bits 39:34 and 25 are reserved zero).
    localparam int CW_STATUS_LOAD = 33;
    localparam int CW_MEM_OP_LSB  = 31;
    localparam int CW_PC_FS_LSB   = 29;
    localparam int CW_PC_ADDR     = 28;
    localparam int CW_B_SEL       = 27;
    localparam int CW_IR_LOAD     = 26;
    localparam int CW_FS_LSB      = 20;
    localparam int CW_C0          = 19;
    localparam int CW_K_LSB       = 17;
    localparam int CW_MEM_WRITE   = 16;
    localparam int CW_REG_WRITE   = 15;
    localparam int CW_DA_LSB      = 10;
    localparam int CW_SA_LSB      = 5;
    localparam int CW_SB_LSB      = 0;

    typedef struct packed {
        logic       status_load;
        mem_op_t    mem_op;
        pc_fs_t     pc_fs;
        logic       pc_addr;
        logic       b_sel;
        logic       ir_load;
        fs_t        fs;
        logic       c0;
        logic       mem_write;
        logic       reg_write;
        logic [4:0] da;
        logic [4:0] sa;
        logic [4:0] sb;
    } cw_fields_t;

    // Builds a non-idle ControlWord; the fixed 2'b11 field is only present
    // in active words, idle states emit an all-zero word instead.
    function automatic logic [CW_W-1:0] pack_cw(input cw_fields_t f);
        logic [CW_W-1:0] cw;
        cw = '0;
        cw[CW_STATUS_LOAD]        = f.status_load;
        cw[CW_MEM_OP_LSB +: 2]    = f.mem_op;
        cw[CW_PC_FS_LSB +: 2]     = f.pc_fs;
        cw[CW_PC_ADDR]            = f.pc_addr;
        cw[CW_B_SEL]              = f.b_sel;
        cw[CW_IR_LOAD]            = f.ir_load;
        cw[CW_FS_LSB +: 5]        = f.fs;
        cw[CW_C0]                 = f.c0;
        cw[CW_K_LSB +: 2]         = 2'b11;
        cw[CW_MEM_WRITE]          = f.mem_write;
        cw[CW_REG_WRITE]          = f.reg_write;
        cw[CW_DA_LSB +: 5]        = f.da;
        cw[CW_SA_LSB +: 5]        = f.sa;
        cw[CW_SB_LSB +: 5]        = f.sb;
        return cw;
    endfunction

    // Evaluates a B.cond condition against registered flags {V,C,N,Z}.
    // Code 4'hF behaves like AL.
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
        logic v, c, n, z;
        logic res;
        v = flags[3];
        c = flags[2];
        n = flags[1];
        z = flags[0];
        case (cond)
            4'h0:    res = z;
            4'h1:    res = ~z;
            4'h2:    res = c;
            4'h3:    res = ~c;
            4'h4:    res = n;
            4'h5:    res = ~n;
            4'h6:    res = v;
            4'h7:    res = ~v;
            4'h8:    res = c & ~z;
            4'h9:    res = ~(c & ~z);
            4'hA:    res = (n == v);
            4'hB:    res = (n != v);
            4'hC:    res = ~z & (n == v);
            4'hD:    res = ~(~z & (n == v));
            default: res = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/legv8_control_unit_if.sv
// ---------------------------------------------------------------------------
// legv8_control_unit_if
// Bundle between the datapath and the control unit.
//   IR_out[31:0]        datapath -> CU  instruction register
//   status[4:0]         datapath -> CU  live ALU flags {Z5,V,C,N,Z}
//   current_status[3:0] datapath -> CU  registered flags {V,C,N,Z}
//   ControlWord[39:0]   CU -> datapath  control word
//   constant[63:0]      CU -> datapath  extended immediate / branch offset
//   state[2:0]          CU -> observer  current FSM state
//   halted              CU -> observer  high while halted
// Modports: master = datapath side, slave = control unit.
// ---------------------------------------------------------------------------
interface legv8_control_unit_if;
    import legv8_pkg::*;

    logic [31:0]       IR_out;
    logic [4:0]        status;
    logic [3:0]        current_status;
    logic [CW_W-1:0]   ControlWord;
    logic [DATA_W-1:0] constant;
    logic [2:0]        state;
    logic              halted;

    modport master (
        output IR_out, status, current_status,
        input  ControlWord, constant, state, halted
    );

    modport slave (
        input  IR_out, status, current_status,
        output ControlWord, constant, state, halted
    );

endinterface

// File: rtl/legv8_imm_extend.sv
// ---------------------------------------------------------------------------
// legv8_imm_extend
// Combinational immediate extender: picks the immediate field of the
// instruction according to the format select and widens it to 64 bits.
//   i_ir[31:0]      instruction word
//   i_fmt           immediate format (imm_fmt_t)
//   o_constant[63:0] extended value (zero for IMM_NONE)
// ---------------------------------------------------------------------------
module legv8_imm_extend
    import legv8_pkg::*;
(
    input  logic [31:0]       i_ir,
    input  imm_fmt_t          i_fmt,
    output logic [DATA_W-1:0] o_constant
);

    // I-format immediates are unsigned; D, B and CB are signed, and branch
    // offsets are word counts so they are scaled by 4.
    always_comb begin
        o_constant = '0;
        case (i_fmt)
            IMM_I:   o_constant = {52'd0, i_ir[21:10]};
            IMM_D:   o_constant = {{55{i_ir[20]}}, i_ir[20:12]};
            IMM_B:   o_constant = {{36{i_ir[25]}}, i_ir[25:0], 2'b00};
            IMM_CB:  o_constant = {{43{i_ir[23]}}, i_ir[23:5], 2'b00};
            default: o_constant = '0;
        endcase
    end

endmodule

// File: rtl/legv8_control_unit.sv
// ---------------------------------------------------------------------------
// legv8_control_unit
// Multi-cycle FSM control unit driving LEGv8_Datapath_TS. Sequences
// RST -> FETCH -> DECODE -> EXEC (-> MEM for LDUR) -> FETCH, with HALT
// absorbing until reset. Decodes IR_out into the 40-bit ControlWord and the
// 64-bit constant, and resolves conditional branches.
//   clock   rising-edge clock
//   reset   asynchronous, active-low reset
//   bus     legv8_control_unit_if.slave (IR_out, status, current_status in;
//           ControlWord, constant, state, halted out)
// Optional feature macro: LEGV8_CU_BCOND_EN enables B.cond decode; without it
// B.cond executes as a NOP.
// ---------------------------------------------------------------------------
module legv8_control_unit
    import legv8_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    legv8_control_unit_if.slave   bus
);

    state_t            r_state;
    state_t            w_next_state;
    cw_fields_t        w_fetch;
    cw_fields_t        w_exec;
    cw_fields_t        w_mem;
    imm_fmt_t          w_fmt;
    logic              w_is_ldur;
    logic              w_is_hlt;
    logic [CW_W-1:0]   w_cw;
    logic [DATA_W-1:0] w_constant;
    logic [DATA_W-1:0] w_ext;
    logic              w_halted;

    logic [10:0] w_opc11;
    logic [9:0]  w_opc10;
    logic [7:0]  w_opc8;
    logic [5:0]  w_opc6;
    logic [4:0]  w_rd;
    logic [4:0]  w_rn;
    logic [4:0]  w_rm;
    logic        w_unused;

    assign w_opc11 = bus.IR_out[31:21];
    assign w_opc10 = bus.IR_out[31:22];
    assign w_opc8  = bus.IR_out[31:24];
    assign w_opc6  = bus.IR_out[31:26];
    assign w_rd    = bus.IR_out[4:0];
    assign w_rn    = bus.IR_out[9:5];
    assign w_rm    = bus.IR_out[20:16];

    // Only the live Z flag matters here; the other flag bits are consumed
    // only when B.cond support is compiled in.
    assign w_unused = &{1'b0, bus.status[4:1], bus.current_status};

    legv8_imm_extend u_imm_extend (
        .i_ir       (bus.IR_out),
        .i_fmt      (w_fmt),
        .o_constant (w_ext)
    );

    // State register; reset forces RST immediately so the word goes to zero
    // in the same cycle, aborting any instruction in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Instruction decode: builds the EXEC and MEM field sets and selects the
    // immediate format. Longer opcodes are matched before shorter ones so a
    // short-opcode match can never shadow an exact 11-bit opcode.
    always_comb begin
        w_fetch         = '0;
        w_fetch.mem_op  = MEM_IFETCH;
        w_fetch.pc_fs   = PC_HOLD;
        w_fetch.pc_addr = 1'b1;
        w_fetch.ir_load = 1'b1;
        w_fetch.b_sel   = 1'b1;

        w_exec       = '0;
        w_exec.pc_fs = PC_INC;
        w_fmt        = IMM_NONE;
        w_is_ldur    = 1'b0;
        w_is_hlt     = 1'b0;

        if ((w_opc11 == OPC_ADD) || (w_opc11 == OPC_SUB) ||
            (w_opc11 == OPC_AND) || (w_opc11 == OPC_ORR)) begin
            w_exec.reg_write = 1'b1;
            w_exec.da        = w_rd;
            w_exec.sa        = w_rn;
            w_exec.sb        = w_rm;
            case (w_opc11)
                OPC_SUB: begin
                    w_exec.fs          = FS_SUB;
                    w_exec.c0          = 1'b1;
                    w_exec.status_load = 1'b1;
                end
                OPC_AND: w_exec.fs = FS_AND;
                OPC_ORR: w_exec.fs = FS_ORR;
                default: w_exec.fs = FS_ADD;
            endcase
        end else if (w_opc11 == OPC_STUR) begin
            w_exec.sa        = w_rn;
            w_exec.sb        = w_rd;
            w_exec.b_sel     = 1'b1;
            w_exec.fs        = FS_ADD;
            w_exec.mem_op    = MEM_WRITE;
            w_exec.mem_write = 1'b1;
            w_fmt            = IMM_D;
        end else if (w_opc11 == OPC_LDUR) begin
            w_exec.sa     = w_rn;
            w_exec.b_sel  = 1'b1;
            w_exec.fs     = FS_ADD;
            w_exec.mem_op = MEM_DREAD;
            w_exec.pc_fs  = PC_HOLD;
            w_fmt         = IMM_D;
            w_is_ldur     = 1'b1;
        end else if (w_opc11 == OPC_HLT) begin
            w_exec.pc_fs = PC_HOLD;
            w_is_hlt     = 1'b1;
        end else if ((w_opc10 == OPC_ADDI) || (w_opc10 == OPC_SUBI) ||
                     (w_opc10 == OPC_ANDI) || (w_opc10 == OPC_ORRI)) begin
            w_exec.reg_write = 1'b1;
            w_exec.da        = w_rd;
            w_exec.sa        = w_rn;
            w_exec.b_sel     = 1'b1;
            w_fmt            = IMM_I;
            case (w_opc10)
                OPC_SUBI: begin
                    w_exec.fs          = FS_SUB;
                    w_exec.c0          = 1'b1;
                    w_exec.status_load = 1'b1;
                end
                OPC_ANDI: w_exec.fs = FS_AND;
                OPC_ORRI: w_exec.fs = FS_ORR;
                default:  w_exec.fs = FS_ADD;
            endcase
        end else if ((w_opc8 == OPC_CBZ) || (w_opc8 == OPC_CBNZ)) begin
            // Rt passes through the ALU (Rt + XZR) so the datapath's live Z
            // flag reflects Rt == 0 during this same cycle.
            w_exec.sa = w_rd;
            w_exec.sb = XZR;
            w_exec.fs = FS_ADD;
            w_fmt     = IMM_CB;
            if ((w_opc8 == OPC_CBZ) == bus.status[0]) begin
                w_exec.pc_fs = PC_REL;
            end
        end
`ifdef LEGV8_CU_BCOND_EN
        else if (w_opc8 == OPC_BCOND) begin
            w_fmt = IMM_CB;
            if (cond_holds(bus.IR_out[3:0], bus.current_status)) begin
                w_exec.pc_fs = PC_REL;
            end
        end
`endif
        else if (w_opc6 == OPC_B) begin
            w_exec.pc_fs = PC_REL;
            w_fmt        = IMM_B;
        end

        // LDUR write-back repeats the load word, now committing Rt and
        // advancing the PC that was held during EXEC.
        w_mem           = w_exec;
        w_mem.reg_write = 1'b1;
        w_mem.da        = w_rd;
        w_mem.pc_fs     = PC_INC;
    end

    // Next-state and output selection; idle states emit an all-zero word.
    always_comb begin
        w_next_state = r_state;
        w_cw         = '0;
        w_constant   = '0;
        w_halted     = 1'b0;
        case (r_state)
            ST_RST: begin
                w_next_state = ST_FETCH;
            end
            ST_FETCH: begin
                w_cw         = pack_cw(w_fetch);
                w_next_state = ST_DECODE;
            end
            ST_DECODE: begin
                w_constant   = w_ext;
                w_next_state = ST_EXEC;
            end
            ST_EXEC: begin
                w_cw       = pack_cw(w_exec);
                w_constant = w_ext;
                if (w_is_hlt) begin
                    w_next_state = ST_HALT;
                end else if (w_is_ldur) begin
                    w_next_state = ST_MEM;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_MEM: begin
                w_cw         = pack_cw(w_mem);
                w_constant   = w_ext;
                w_next_state = ST_FETCH;
            end
            ST_HALT: begin
                w_halted = 1'b1;
            end
            default: begin
                w_next_state = ST_RST;
            end
        endcase
    end

    assign bus.ControlWord = w_cw;
    assign bus.constant    = w_constant;
    assign bus.state       = r_state;
    assign bus.halted      = w_halted;

endmodule
